// File: rtl/cymometer_pkg.sv
// Shared types and constants for the cymometer measurement sequencer.
package cymometer_pkg;

   localparam int RANGE_W = 2;
   localparam int GATE_W  = 30;
   localparam int DATA_W  = 20;
   localparam int FX_W    = 32;
   localparam int TIMER_W = 31;

   localparam logic [FX_W-1:0] LO_THR_DEF = 32'd1000;
   localparam logic [FX_W-1:0] HI_THR_DEF = 32'd100000;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      RANGE,
      PUBLISH
   } cym_state_t;

   // Gate length for a range: each range step is four times longer.
   function automatic logic [GATE_W-1:0] gate_for_range(
      input logic [23:0]        gate_min,
      input logic [RANGE_W-1:0] rng
   );
      gate_for_range = {6'd0, gate_min} << {rng, 1'b0};
   endfunction

endpackage

// File: rtl/cym_timer.sv
// Loadable down-counter guarding the WAIT state against a missing input signal.
// expire flags the enabled cycle on which the count reaches zero.
module cym_timer
   import cymometer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               en,
   input  logic [TIMER_W-1:0] load_val,
   output logic               expire
);

   logic [TIMER_W-1:0] count_reg;

   // Load has priority; otherwise count down while enabled, holding at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   // A count of 1 becomes 0 on this edge; 0 is included so a stale zero still ends the wait.
   assign expire = en && !load && (count_reg <= {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cymometer_ctrl.sv
// Measurement sequencer for the equal-precision frequency counter.
// Issues start pulses, auto-ranges the gate length, detects a missing signal
// by timeout and hands results to the display path over valid/ready.
// Build option: define CYM_AUTORANGE_EN to enable auto-ranging; otherwise the
// range stays at RANGE_INIT permanently.
module cymometer_ctrl
   import cymometer_pkg::*;
#(
   parameter logic [25:0]      CLK_FS     = 26'd50000000,
   parameter logic [23:0]      GATE_MIN   = 24'd500000,
   parameter logic [23:0]      TIMEOUT    = 24'd1000000,
   parameter logic [FX_W-1:0]  LO_THR     = LO_THR_DEF,
   parameter logic [FX_W-1:0]  HI_THR     = HI_THR_DEF,
   parameter logic [1:0]       RANGE_INIT = 2'd2
)(
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                enable,
   output logic                meas_start,
   output logic [GATE_W-1:0]   gate_len,
   input  logic                meas_done,
   input  logic [FX_W-1:0]     meas_fx_cnt,
   input  logic [DATA_W-1:0]   meas_data,
   output logic [DATA_W-1:0]   res_data,
   output logic [RANGE_W-1:0]  res_range,
   output logic                res_nosig,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy
);

`ifdef CYM_AUTORANGE_EN
   localparam bit AUTORANGE = 1'b1;
`else
   localparam bit AUTORANGE = 1'b0;
`endif

   // A zero gate or clock frequency would make every measurement meaningless.
   if ((GATE_MIN == 24'd0) || (CLK_FS == 26'd0)) begin : g_bad_param
      $error("cymometer_ctrl: GATE_MIN and CLK_FS must be non-zero");
   end

   cym_state_t          state_reg;
   logic [RANGE_W-1:0]  range_reg;
   logic [RANGE_W-1:0]  range_next;
   logic [DATA_W-1:0]   data_cap_reg;
   logic [FX_W-1:0]     fx_cap_reg;
   logic                nosig_cap_reg;
   logic                timer_expire;
   logic [TIMER_W-1:0]  timer_load_val;

   // gate_len is held from the start pulse until done, so the sum is stable at load time.
   assign timer_load_val = {1'b0, gate_len} + {{(TIMER_W-24){1'b0}}, TIMEOUT};

   cym_timer u_timer (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .load     (state_reg == START),
      .en       (state_reg == WAIT),
      .load_val (timer_load_val),
      .expire   (timer_expire)
   );

   // Range for the next measurement, derived from the one just captured.
   always_comb begin
      range_next = range_reg;
      if (AUTORANGE) begin
         if (nosig_cap_reg) begin
            range_next = 2'd3;
         end else if ((fx_cap_reg < LO_THR) && (range_reg != 2'd3)) begin
            range_next = range_reg + 2'd1;
         end else if ((fx_cap_reg > HI_THR) && (range_reg != 2'd0)) begin
            range_next = range_reg - 2'd1;
         end
      end else begin
         range_next = RANGE_INIT;
      end
   end

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= IDLE;
         meas_start    <= 1'b0;
         gate_len      <= gate_for_range(GATE_MIN, RANGE_INIT);
         range_reg     <= RANGE_INIT;
         data_cap_reg  <= '0;
         fx_cap_reg    <= '0;
         nosig_cap_reg <= 1'b0;
         res_data      <= '0;
         res_range     <= RANGE_INIT;
         res_nosig     <= 1'b0;
         res_valid     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         meas_start <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg <= START;
                  busy      <= 1'b1;
               end
            end
            START: begin
               meas_start <= 1'b1;
               state_reg  <= WAIT;
            end
            WAIT: begin
               // Done is checked first so it wins over a same-cycle timeout.
               if (meas_done) begin
                  data_cap_reg  <= meas_data;
                  fx_cap_reg    <= meas_fx_cnt;
                  nosig_cap_reg <= 1'b0;
                  state_reg     <= RANGE;
               end else if (timer_expire) begin
                  data_cap_reg  <= '0;
                  fx_cap_reg    <= '0;
                  nosig_cap_reg <= 1'b1;
                  state_reg     <= RANGE;
               end
            end
            RANGE: begin
               range_reg <= range_next;
               gate_len  <= gate_for_range(GATE_MIN, range_next);
               res_data  <= data_cap_reg;
               res_range <= range_reg;
               res_nosig <= nosig_cap_reg;
               state_reg <= PUBLISH;
            end
            PUBLISH: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  res_valid <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cymometer_ctrl.sv
// Scoreboard bench for cymometer_ctrl: the stimulus side plays the counter core
// and queues expected results; a monitor pops and compares on every accept.
module tb_cymometer_ctrl;

`ifdef CYM_AUTORANGE_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct packed {
      logic [19:0] data;
      logic [1:0]  rng;
      logic        nosig;
   } res_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        meas_done = 1'b0;
   logic [31:0] meas_fx_cnt = '0;
   logic [19:0] meas_data = '0;
   logic        res_ready = 1'b0;
   logic        meas_start;
   logic [29:0] gate_len;
   logic [19:0] res_data;
   logic [1:0]  res_range;
   logic        res_nosig;
   logic        res_valid;
   logic        busy;

   int   errors = 0;
   int   checks = 0;
   res_t exp_q[$];

   always #5 sys_clk = ~sys_clk;

   cymometer_ctrl #(
      .GATE_MIN   (24'd100),
      .TIMEOUT    (24'd50),
      .RANGE_INIT (2'd0)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .enable      (enable),
      .meas_start  (meas_start),
      .gate_len    (gate_len),
      .meas_done   (meas_done),
      .meas_fx_cnt (meas_fx_cnt),
      .meas_data   (meas_data),
      .res_data    (res_data),
      .res_range   (res_range),
      .res_nosig   (res_nosig),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: every accepted result is compared against the oldest expectation.
   always @(negedge sys_clk) begin : monitor
      res_t e;
      if (sys_rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: data=%0d with no expectation queued", res_data);
         end else begin
            e = exp_q.pop_front();
            check("res_data",  32'(res_data),  32'(e.data));
            check("res_range", 32'(res_range), 32'(e.rng));
            check("res_nosig", 32'(res_nosig), 32'(e.nosig));
         end
      end
   end

   // Waits (bounded) for a start pulse and checks the gate length offered with it.
   task automatic wait_start(input string name, input logic [29:0] exp_gate);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!meas_start && n < 2000);
      if (!meas_start) begin
         checks++;
         errors++;
         $display("FAIL %s_start: no meas_start within %0d cycles, got 0 expected 1", name, n);
      end else begin
         check({name, "_gate"}, 32'(gate_len), 32'(exp_gate));
      end
   endtask

   // One core measurement: done arrives 'delay' edges after the start pulse edge + 1.
   task automatic run_meas(input string name, input logic [29:0] exp_gate, input int delay,
                           input logic [31:0] fx, input logic [19:0] data, input logic [1:0] exp_rng);
      wait_start(name, exp_gate);
      exp_q.push_back(res_t'{data, exp_rng, 1'b0});
      repeat (delay) @(posedge sys_clk);
      #1;
      meas_fx_cnt = fx;
      meas_data   = data;
      meas_done   = 1'b1;
      @(posedge sys_clk);
      #1;
      meas_done = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int   n;
      int   bad;
      logic [19:0] held;

      res_ready = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_meas_start", 32'(meas_start), 32'd0);
      check("rst_gate_len",   32'(gate_len),   32'd100);
      check("rst_res_data",   32'(res_data),   32'd0);
      check("rst_res_range",  32'(res_range),  32'd0);
      check("rst_res_nosig",  32'(res_nosig),  32'd0);
      check("rst_res_valid",  32'(res_valid),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      enable = 1'b1;

      run_meas("normal", 30'd100, 120, 32'd5000, 20'd12345, 2'd0);

      // No done at all: result appears 151 cycles after the start pulse ends.
      wait_start("timeout", 30'd100);
      exp_q.push_back(res_t'{20'd0, 2'd0, 1'b1});
      @(negedge sys_clk);
      check("start_one_cycle", 32'(meas_start), 32'd0);
      check("busy_in_wait",    32'(busy),       32'd1);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!res_valid && n < 400);
      check("timeout_latency", 32'(n), 32'd151);

      // Large counts walk the range back down, then stay at the floor.
      run_meas("down1", AR ? 30'd6400 : 30'd100, 20, 32'd200000, 20'd1, AR ? 2'd3 : 2'd0);
      run_meas("down2", AR ? 30'd1600 : 30'd100, 20, 32'd200000, 20'd2, AR ? 2'd2 : 2'd0);
      run_meas("down3", AR ? 30'd400  : 30'd100, 20, 32'd200000, 20'd3, AR ? 2'd1 : 2'd0);
      run_meas("floor", 30'd100,                 20, 32'd200000, 20'd4, 2'd0);

      // Small counts lengthen the gate until it saturates at range 3.
      run_meas("up1",   30'd100,                 20, 32'd10, 20'd11, 2'd0);
      run_meas("up2",   AR ? 30'd400  : 30'd100, 20, 32'd10, 20'd12, AR ? 2'd1 : 2'd0);
      run_meas("up3",   AR ? 30'd1600 : 30'd100, 20, 32'd10, 20'd13, AR ? 2'd2 : 2'd0);
      run_meas("up4",   AR ? 30'd6400 : 30'd100, 20, 32'd10, 20'd14, AR ? 2'd3 : 2'd0);
      run_meas("upsat", AR ? 30'd6400 : 30'd100, 20, 32'd10, 20'd15, AR ? 2'd3 : 2'd0);

      run_meas("back1", AR ? 30'd6400 : 30'd100, 20, 32'd200000, 20'd21, AR ? 2'd3 : 2'd0);
      run_meas("back2", AR ? 30'd1600 : 30'd100, 20, 32'd200000, 20'd22, AR ? 2'd2 : 2'd0);
      run_meas("back3", AR ? 30'd400  : 30'd100, 20, 32'd200000, 20'd23, AR ? 2'd1 : 2'd0);

      // Done sampled on the same edge the timer reaches zero: done wins.
      run_meas("coinc", 30'd100, 149, 32'd5000, 20'd777, 2'd0);

      // Hold the coincident result under back-pressure.
      res_ready = 1'b0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!res_valid && n < 50);
      check("bp_valid_seen", 32'(res_valid), 32'd1);
      held = res_data;
      bad  = 0;
      repeat (500) begin
         @(negedge sys_clk);
         if (!res_valid || res_data !== held || res_nosig !== 1'b0 || meas_start)
            bad++;
      end
      check("bp_held_data", 32'(held), 32'd777);
      check("bp_violations", 32'(bad), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);

      @(posedge sys_clk); #1;
      res_ready = 1'b1;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!meas_start && n < 50);
      check("bp_restart_latency", 32'(n), 32'd4);

      // Reset while the restarted measurement is in WAIT.
      repeat (10) @(posedge sys_clk);
      #1;
      enable    = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check("arst_meas_start", 32'(meas_start), 32'd0);
      check("arst_gate_len",   32'(gate_len),   32'd100);
      check("arst_res_data",   32'(res_data),   32'd0);
      check("arst_res_range",  32'(res_range),  32'd0);
      check("arst_res_valid",  32'(res_valid),  32'd0);
      check("arst_busy",       32'(busy),       32'd0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      bad = 0;
      repeat (300) begin
         @(negedge sys_clk);
         if (meas_start || busy || res_valid)
            bad++;
      end
      check("idle_after_reset", 32'(bad), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
